psum_accum_buffer: RTL and testbench
====================================

# psum_accum_buffer

Downstream consumer of the spatial-unrolling adder. It accepts the 512-bit reduced psum words and their BRAM addresses, and accumulates them lane-wise into an on-chip psum buffer using read-modify-write. The first temporal pass overwrites instead of accumulating. On conv_finish it streams the finished buffer contents out with a valid/ready handshake, toward the output GBF / DRAM writer.

## Interface
- GBF_DATA_BITWIDTH, 512: width of one buffer word.
- DATA_BITWIDTH, 16: lane width; lanes = GBF_DATA_BITWIDTH/DATA_BITWIDTH (32).
- ADDR_BITWIDTH, 10: buffer address width.
- DEPTH, 1024: buffer words.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_data  in  GBF_DATA_BITWIDTH  psum word from su_adder out_data.
- in_write_en  in  1  word valid (su_adder psum_write_en); accepted only when in_ready=1.
- in_addr  in  ADDR_BITWIDTH  target word (su_adder psum_BRAM_addr).
- first_pass  in  1  1: overwrite; 0: accumulate. Sampled with the word.
- in_ready  out  1  block accepts input words.
- conv_finish  in  1  one-cycle pulse; starts flush and drain.
- drain_len  in  ADDR_BITWIDTH+1  words to drain (addresses 0..drain_len-1); sampled with conv_finish.
- out_data  out  GBF_DATA_BITWIDTH  drained word.
- out_addr  out  ADDR_BITWIDTH  address of out_data.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  consumer accepts the word.
- drain_done  out  1  one-cycle pulse after the last drain handshake.

## Operation
- FSM states: IDLE, FLUSH, DRAIN, DONE. Reset enters IDLE.
- in_ready is 1 only in IDLE. In other states in_write_en is ignored and no word is written.
- Accumulate pipeline:
  - Edge T: an accepted word registers into stage 1 (v1, a1, d1, fp1). The buffer read of mem[in_addr] registers into rd_q at the same edge.
  - Cycle after T: sum = fp1 ? d1 : lane-wise (rd_q + d1). Each 16-bit lane adds independently, wraps modulo 2^16, and does not carry between lanes.
  - Edge T+1: sum is written to mem[a1].
- Forwarding: if a word is accepted with in_addr == a1 while v1=1, rd_q loads the sum being written, not the stale memory value. Back-to-back same-address words therefore accumulate correctly. Non-adjacent words need no forwarding.
- conv_finish in IDLE moves the FSM to FLUSH and latches drain_len. A word accepted in the same cycle is included in the drain.
- FLUSH lasts exactly 1 cycle; it lets the stage-1 write complete.
- FSM then moves to DRAIN, or to DONE if drain_len==0.
- DRAIN:
  - The read pointer starts at 0 and issues reads with 1-cycle read latency.
  - The output register holds the word, with out_addr = pointer at issue.
  - While out_valid=1 and out_ready=0, out_data/out_addr stay stable and no new read is issued.
  - After the handshake for address drain_len-1, FSM moves to DONE.
- DONE: drain_done=1 for one cycle, then IDLE.
- conv_finish outside IDLE is ignored.
- Buffer contents are not cleared by reset or by drain. A new convolution must start each address with first_pass=1.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_addr=0, drain_done=0. Pipeline valid v1=0, read pointer=0.
- Write latency: word accepted at edge T is in memory after edge T+1.
- conv_finish sampled at edge T:
  - FLUSH during cycle T..T+1, DRAIN entered at edge T+1.
  - First out_valid after edge T+2.
  - With out_ready held at 1, one word per cycle; last word valid after edge T+1+drain_len.
  - drain_done high in the cycle after the final handshake edge.
- Reset asserted mid-DRAIN: at the next edge the FSM returns to IDLE with all outputs at reset values. The partial drain is abandoned and the pending stage-1 write is discarded.

## Test plan
- Overwrite then accumulate: addr 5, all lanes 16'd1, first_pass=1; then addr 5, all lanes 16'd3, first_pass=0; drain_len=6 -> word 5 has all lanes 16'h0004.
- Forwarding: addr 2 receives 4 consecutive words, each lane 16'd1, first word first_pass=1 -> drained word 2 has all lanes 16'h0004.
- Lane wrap: lane 0 = 16'hFFFF, then accumulate lane 0 = 16'h0002 -> lane 0 = 16'h0001, lane 1 unaffected (no carry).
- Backpressure: drain_len=4, out_ready toggled 1,0,0,1,... -> out_addr sequence 0,1,2,3 with no skips or duplicates, data stable while stalled, exactly one drain_done pulse.
- conv_finish coincident with a write to addr 0 (first_pass=1, 16'h00AA lanes) -> drain word 0 = 16'h00AA lanes; in_ready=0 from the next cycle until after drain_done.
- Reset low during DRAIN at word 1 -> next cycle out_valid=0, in_ready=1, drain_done never pulses; a new conv_finish drains again from addr 0.

Source files
------------

// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer: lane-wise read-modify-write psum buffer with flush and valid/ready drain
module psum_accum_buffer #(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH     = 10,
  parameter int DEPTH             = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [GBF_DATA_BITWIDTH-1:0] in_data,
  input  logic                         in_write_en,
  input  logic [ADDR_BITWIDTH-1:0]     in_addr,
  input  logic                         first_pass,
  output logic                         in_ready,
  input  logic                         conv_finish,
  input  logic [ADDR_BITWIDTH:0]       drain_len,
  output logic [GBF_DATA_BITWIDTH-1:0] out_data,
  output logic [ADDR_BITWIDTH-1:0]     out_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         drain_done
);
  localparam int LANES = GBF_DATA_BITWIDTH / DATA_BITWIDTH;
  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, DONE} state_t;
  state_t state;
  logic [GBF_DATA_BITWIDTH-1:0] mem [DEPTH];
  logic [GBF_DATA_BITWIDTH-1:0] d1, rd_q, sum;
  logic [ADDR_BITWIDTH-1:0] a1;
  logic v1, fp1, accept, fire, last;
  logic [ADDR_BITWIDTH:0] len_q, ptr;
  assign in_ready = state == IDLE;
  assign accept = in_ready && in_write_en;
  assign fire = out_valid && out_ready;
  assign last = {1'b0, out_addr} == len_q - 1'b1;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign sum[g*DATA_BITWIDTH +: DATA_BITWIDTH] = fp1 ? d1[g*DATA_BITWIDTH +: DATA_BITWIDTH] :
      rd_q[g*DATA_BITWIDTH +: DATA_BITWIDTH] + d1[g*DATA_BITWIDTH +: DATA_BITWIDTH];
  end
  // A word landing on the address being written this edge takes the fresh sum, not the stale memory.
  always_ff @(posedge clk) begin
    if (reset && v1) mem[a1] <= sum;
    rd_q <= (v1 && in_addr == a1) ? sum : mem[in_addr];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      v1         <= 1'b0;
      a1         <= '0;
      d1         <= '0;
      fp1        <= 1'b0;
      len_q      <= '0;
      ptr        <= '0;
      out_data   <= '0;
      out_addr   <= '0;
      out_valid  <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a1  <= in_addr;
        d1  <= in_data;
        fp1 <= first_pass;
      end
      drain_done <= 1'b0;
      case (state)
        IDLE: if (conv_finish) begin
          state <= FLUSH;
          len_q <= drain_len;
        end
        FLUSH: begin
          ptr        <= '0;
          state      <= (len_q == '0) ? DONE : DRAIN;
          drain_done <= len_q == '0;
        end
        DRAIN: if (fire && last) begin
          out_valid  <= 1'b0;
          state      <= DONE;
          drain_done <= 1'b1;
        end else if ((!out_valid || out_ready) && ptr < len_q) begin
          out_data  <= mem[ptr[ADDR_BITWIDTH-1:0]];
          out_addr  <= ptr[ADDR_BITWIDTH-1:0];
          out_valid <= 1'b1;
          ptr       <= ptr + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_accum_buffer.sv
// tb_psum_accum_buffer: random and directed stimulus against a cycle-level behavioural model
module tb_psum_accum_buffer;
  localparam int W = 512, AW = 10, L = 32;
  logic clk = 0, reset = 0, in_write_en = 0, first_pass = 0, conv_finish = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic [AW-1:0] in_addr = '0;
  logic [AW:0] drain_len = '0;
  logic in_ready, out_valid, drain_done;
  logic [W-1:0] out_data;
  logic [AW-1:0] out_addr;

  psum_accum_buffer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_write_en(in_write_en), .in_addr(in_addr),
    .first_pass(first_pass), .in_ready(in_ready), .conv_finish(conv_finish), .drain_len(drain_len),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [W-1:0] model_mem [1024];
  logic [W-1:0] cap [1024];
  logic busy = 0, flush = 0, done_due = 0, armed = 0, pv = 0, pr = 0;
  logic [W-1:0] pd;
  logic [AW-1:0] pa;
  int len_q = 0, nxt = 0, cyc = 0, done_cnt = 0, done_at = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int l = 0; l < L; l++) r[l*16 +: 16] = a[l*16 +: 16] + b[l*16 +: 16];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd512();
    logic [W-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Protocol model: busy from the edge that samples conv_finish until drain_done has been shown.
  always @(negedge clk) begin
    logic hs, start, n_done;
    if (armed) begin
      chk("in_ready", in_ready, !busy);
      chk("drain_done", drain_done, done_due);
      if (drain_done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (out_valid) begin
        if (!busy || flush || nxt >= len_q) chk("spurious_valid", out_valid, 1'b0);
        else begin
          chk("out_addr", out_addr, nxt[AW-1:0]);
          chk("out_data", out_data, model_mem[nxt]);
        end
      end
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_addr", out_addr, pa);
        chk("stall_data", out_data, pd);
      end
      hs = reset && busy && out_valid && out_ready;
      n_done = reset && busy && ((hs && nxt == len_q - 1) || (flush && len_q == 0));
      start = reset && !busy && conv_finish;
      if (hs) begin
        cap[out_addr] = out_data;
        nxt++;
      end
      if (reset && !busy && in_write_en)
        model_mem[in_addr] = first_pass ? in_data : lane_add(model_mem[in_addr], in_data);
      if (!reset || done_due) busy = 0;
      else if (start) begin
        busy = 1;
        len_q = int'(drain_len);
        nxt = 0;
      end
      done_due = n_done;
      flush = start;
      pv = reset && out_valid;
      pr = out_ready;
      pd = out_data;
      pa = out_addr;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic fp);
    in_write_en = 1;
    in_addr = a;
    in_data = d;
    first_pass = fp;
    tick();
    in_write_en = 0;
  endtask

  task automatic drain(input int len, input int mode);
    int c0, d0, n;
    for (int i = 0; i < len; i++) cap[i] = 'x;
    c0 = cyc;
    d0 = done_cnt;
    conv_finish = 1;
    drain_len = len[AW:0];
    tick();
    conv_finish = 0;
    in_write_en = 0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 4 == 0 || n % 4 == 3) : 1'($urandom_range(0, 1));
      if (mode == 2) begin
        in_write_en = 1'($urandom_range(0, 1));
        in_addr = AW'($urandom_range(0, 15));
        in_data = rnd512();
        first_pass = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    in_write_en = 0;
    chk("drain_timeout", done_cnt != d0, 1'b1);
    if (mode == 0) chk("drain_latency", done_at - c0, (len == 0) ? 2 : len + 3);
    repeat (3) tick();
    chk("done_pulses", done_cnt - d0, 1);
    chk("drain_count", nxt, len);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] t;
    int d0, n;
    @(posedge clk);
    #1;
    armed = 1;
    repeat (2) tick();
    chk("rst_out_data", out_data, '0);
    chk("rst_out_addr", out_addr, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_drain_done", drain_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset = 1;
    tick();
    for (int a = 0; a < 16; a++) wr(AW'(a), '0, 1'b1);

    wr(5, {L{16'd1}}, 1'b1);
    wr(5, {L{16'd3}}, 1'b0);
    drain(6, 0);
    chk("model_acc5", model_mem[5], {L{16'h0004}});
    chk("acc5", cap[5], {L{16'h0004}});

    wr(2, {L{16'd1}}, 1'b1);
    repeat (3) wr(2, {L{16'd1}}, 1'b0);
    drain(6, 0);
    chk("model_fwd2", model_mem[2], {L{16'h0004}});
    chk("fwd2", cap[2], {L{16'h0004}});

    t = '0;
    t[15:0] = 16'hFFFF;
    t[31:16] = 16'h1234;
    wr(7, t, 1'b1);
    t = '0;
    t[15:0] = 16'h0002;
    wr(7, t, 1'b0);
    drain(8, 0);
    t = '0;
    t[31:0] = 32'h1234_0001;
    chk("model_wrap7", model_mem[7], t);
    chk("wrap7", cap[7], t);

    wr(0, rnd512(), 1'b1);
    wr(1, rnd512(), 1'b1);
    wr(3, rnd512(), 1'b1);
    drain(4, 1);

    in_write_en = 1;
    in_addr = 0;
    in_data = {L{16'h00AA}};
    first_pass = 1;
    drain(1, 0);
    chk("coincident0", cap[0], {L{16'h00AA}});

    drain(0, 0);

    conv_finish = 1;
    drain_len = 4;
    tick();
    conv_finish = 0;
    out_ready = 1;
    d0 = done_cnt;
    n = 0;
    while (!(out_valid && out_addr == 1) && n < 20) begin
      tick();
      n++;
    end
    chk("reach_word1", out_valid && out_addr == 1, 1'b1);
    reset = 0;
    tick();
    reset = 1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_data", out_data, '0);
    repeat (6) tick();
    chk("midrst_no_done", done_cnt - d0, 0);
    drain(4, 0);
    chk("redrain0", cap[0], {L{16'h00AA}});

    for (int r = 0; r < 5; r++) begin
      repeat (25) begin
        if ($urandom_range(0, 4) != 0) wr(AW'($urandom_range(0, 15)), rnd512(), $urandom_range(0, 3) == 0);
        else tick();
      end
      drain($urandom_range(1, 16), $urandom_range(1, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
